// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM state encoding and wait-counter width.
package dmem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word storage with byte-enabled synchronous write and registered read.
module dmem_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [IDX_W-1:0]        i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;
  // contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (i_we)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    if (i_re) r_rdata <= r_mem[i_addr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency valid/ready data memory responder.
// The bank is accessed on the edge entering RESP; the response appears one cycle later.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS*4);
  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_valid, r_we, r_err;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_be;
  logic                    w_idle, w_enter, w_we, w_err;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata, w_rdata;
  logic [DATA_WIDTH/8-1:0] w_be;
  // with no wait states the access happens on the acceptance edge, so use live inputs
  assign w_idle  = r_state == IDLE;
  assign w_we    = w_idle ? req_we    : r_we;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_be    = w_idle ? req_be    : r_be;
  assign w_err   = (|w_addr[1:0]) || ({1'b0, w_addr} >= LIMIT);
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        w_next  = WAIT_CYCLES == 0 ? RESP : WAIT;
        w_enter = WAIT_CYCLES == 0;
      end
      WAIT: if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
        w_next  = RESP;
        w_enter = 1'b1;
      end
      RESP: if (r_valid && rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT && w_next == WAIT) ? r_cnt + 1'b1 : '0;
      r_valid <= r_state == RESP && !(r_valid && rsp_ready);
      if (w_idle && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_err   <= w_err;
      end
    end
  end
  dmem_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk    (clk),
    .i_we   (w_enter && !w_err && w_we),
    .i_re   (w_enter && !w_err && !w_we),
    .i_be   (w_be),
    .i_addr (w_addr[IDX_W+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  assign req_ready = w_idle;
  assign rsp_valid = r_valid;
  assign rsp_err   = r_valid && r_err;
  assign rsp_rdata = (r_valid && !r_we && !r_err) ? w_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with WAIT_CYCLES=1 and WAIT_CYCLES=0.
module tb_dmem_responder;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid_b = 1'b0, rsp_ready_b = 1'b1;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;
  int          n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(1'b1),
    .req_addr(32'h40), .req_wdata(32'h5A5A5A5A), .req_be(4'hF), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int lat, output logic [31:0] rd, output logic er);
    int g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_run++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_run++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_run++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    n_run++; if (lat !== 2) begin n_fail++; $display("FAIL st_latency got %0d want 2", lat); end
    n_run++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL st_rsp got %h/%b want 0/0", rd, er); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (lat !== 2) begin n_fail++; $display("FAIL ld_latency got %0d want 2", lat); end
    n_run++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_data got %h want deadbeef", rd); end
    n_run++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", er); end
  endtask

  task automatic test_byte_enable;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, lat, rd, er);
    xact(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge got %h want 11bb33dd", rd); end
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, rd, er);
    n_run++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL be0_rsp got lat %0d err %b want 2/0", lat, er); end
    xact(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be0_noop got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er;
    xact(1'b0, 32'h22, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_ld got %h/%b want 0/1", rd, er); end
    n_run++; if (lat !== 2) begin n_fail++; $display("FAIL misalign_latency got %0d want 2", lat); end
    xact(1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL range_ld got %h/%b want 0/1", rd, er); end
    xact(1'b1, 32'h0, 32'h12345678, 4'hF, lat, rd, er);
    xact(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    n_run++; if (er !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL range_st got err %b lat %0d want 1/2", er, lat); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL range_st_mem got %h want 12345678", rd); end
    xact(1'b1, 32'h12, 32'h0, 4'hF, lat, rd, er);
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL misalign_st_mem got %h want deadbeef", rd); end
  endtask

  task automatic test_hold;
    int lat = 0; logic [31:0] rd; logic er;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_run++; if (lat !== 2) begin n_fail++; $display("FAIL hold_latency got %0d want 2", lat); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d got v %b d %h rdy %b want 1/deadbeef/0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release got v %b rdy %b want 0/1", rsp_valid, req_ready); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_ignored_req got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_inflight;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h30, 32'h0, 4'hF, lat, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_run++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL inflight_busy got %b want 0", req_ready); end
    rst = 1'b0; #1;
    n_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset got v %b rdy %b want 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dropped_rsp got %b want 0", rsp_valid); end
    xact(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er);
    n_run++; if (rd !== 32'h0 || lat !== 2) begin n_fail++; $display("FAIL dropped_store got %h lat %0d want 0/2", rd, lat); end
  endtask

  task automatic test_back_to_back;
    req_valid_b = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      n_run++; if (rsp_valid_b !== (i % 3 == 2)) begin
        n_fail++; $display("FAIL b2b_cycle%0d got %b want %b", i, rsp_valid_b, i % 3 == 2);
      end
    end
    req_valid_b = 1'b0;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_enable;
    test_errors;
    test_hold;
    test_reset_inflight;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
